// File: rtl/fpu_round_arb_if.sv
// Handshake bundle for fpu_round_arb: packed requester fields, dynamic rounding mode,
// and the registered valid/ready result port with the sticky flag accumulator.
interface fpu_round_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 24,
    parameter int EXP_WIDTH = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*WIDTH-1:0]     req_mant;
    logic [NUM_REQ*EXP_WIDTH-1:0] req_exp;
    logic [NUM_REQ-1:0]           req_sign;
    logic [NUM_REQ-1:0]           req_round;
    logic [NUM_REQ-1:0]           req_sticky;
    logic [NUM_REQ*3-1:0]         req_rm;
    logic [2:0]                   frm;

    logic                         out_valid;
    logic                         out_ready;
    logic [ID_W-1:0]              out_id;
    logic [WIDTH-1:0]             out_mant;
    logic [EXP_WIDTH-1:0]         out_exp;
    logic                         out_sign;
    logic [4:0]                   out_flags;
    logic [4:0]                   fflags_acc;
    logic                         fflags_clr;

    modport master (
        output req_valid, req_mant, req_exp, req_sign, req_round, req_sticky, req_rm, frm,
        output out_ready, fflags_clr,
        input  req_ready, out_valid, out_id, out_mant, out_exp, out_sign, out_flags, fflags_acc
    );

    modport slave (
        input  req_valid, req_mant, req_exp, req_sign, req_round, req_sticky, req_rm, frm,
        input  out_ready, fflags_clr,
        output req_ready, out_valid, out_id, out_mant, out_exp, out_sign, out_flags, fflags_acc
    );
endinterface

// File: rtl/fpu_round_arb.sv
// Round-robin arbiter feeding a shared IEEE rounding stage with a one-deep output register.
// Define FPU_RND_DYN_EN to resolve rounding mode 111 (DYN) from frm instead of flagging it.
module fpu_round_arb #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 24,
    parameter int EXP_WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    fpu_round_arb_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int SUM_W = ID_W + 1;
    localparam logic [EXP_WIDTH-1:0] EXP_ALL1 = {EXP_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0] EXP_MAXF = EXP_ALL1 - 1'b1;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [ID_W-1:0]      out_id_q, out_id_d;
    logic [WIDTH-1:0]     out_mant_q, out_mant_d;
    logic [EXP_WIDTH-1:0] out_exp_q, out_exp_d;
    logic                 out_sign_q, out_sign_d;
    logic [4:0]           out_flags_q, out_flags_d;
    logic [4:0]           acc_q, acc_d;

    logic [WIDTH-1:0]     mant_arr [NUM_REQ];
    logic [EXP_WIDTH-1:0] exp_arr  [NUM_REQ];
    logic [2:0]           rm_arr   [NUM_REQ];
    logic [ID_W-1:0]      rot_idx  [NUM_REQ];

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic            stage_free;
    logic            accept;

    // Unpack requester slices and precompute the search order starting at ptr.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [SUM_W-1:0] rot_sum;
            assign mant_arr[gi] = bus.req_mant[gi*WIDTH +: WIDTH];
            assign exp_arr[gi]  = bus.req_exp[gi*EXP_WIDTH +: EXP_WIDTH];
            assign rm_arr[gi]   = bus.req_rm[gi*3 +: 3];
            assign rot_sum      = {1'b0, ptr_q} + SUM_W'(gi);
            assign rot_idx[gi]  = (rot_sum >= SUM_W'(NUM_REQ)) ?
                                  ID_W'(rot_sum - SUM_W'(NUM_REQ)) : rot_sum[ID_W-1:0];
            assign bus.req_ready[gi] = accept && (grant_idx == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && bus.req_valid[rot_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = rot_idx[k];
            end
        end
    end

    assign stage_free = !out_valid_q || bus.out_ready;
    assign accept     = grant_found && stage_free && !rst;

    logic [WIDTH-1:0]     sel_mant;
    logic [EXP_WIDTH-1:0] sel_exp;
    logic                 sel_sign, sel_round, sel_sticky;
    logic [2:0]           sel_rm, rm_src;
    rm_e                  rm_eff;
    logic                 nv, inexact, up, cout, ovf, to_max;
    logic [WIDTH-1:0]     res_mant;
    logic [EXP_WIDTH-1:0] res_exp;
    logic [4:0]           res_flags;

    assign sel_mant   = mant_arr[grant_idx];
    assign sel_exp    = exp_arr[grant_idx];
    assign sel_rm     = rm_arr[grant_idx];
    assign sel_sign   = bus.req_sign[grant_idx];
    assign sel_round  = bus.req_round[grant_idx];
    assign sel_sticky = bus.req_sticky[grant_idx];

`ifndef FPU_RND_DYN_EN
    logic unused_frm;
    assign unused_frm = ^bus.frm;
`endif

    always_comb begin
        rm_src = sel_rm;
`ifdef FPU_RND_DYN_EN
        if (sel_rm == 3'b111) rm_src = bus.frm;
`endif
        rm_eff = RM_RTZ;
        nv     = 1'b0;
        case (rm_src)
            3'b000:  rm_eff = RM_RNE;
            3'b001:  rm_eff = RM_RTZ;
            3'b010:  rm_eff = RM_RDN;
            3'b011:  rm_eff = RM_RUP;
            3'b100:  rm_eff = RM_RMM;
            default: begin
                rm_eff = RM_RTZ;
                nv     = 1'b1;
            end
        endcase

        inexact = sel_round | sel_sticky;
        case (rm_eff)
            RM_RNE:  up = sel_round & (sel_sticky | sel_mant[0]);
            RM_RDN:  up = inexact & sel_sign;
            RM_RUP:  up = inexact & !sel_sign;
            RM_RMM:  up = sel_round;
            default: up = 1'b0;
        endcase
        cout = up & (&sel_mant);

        // Overflow is judged on exp+1, so the top finite binade saturates in every mode.
        ovf    = (sel_exp >= EXP_MAXF);
        to_max = (rm_eff == RM_RTZ) || (rm_eff == RM_RDN && !sel_sign) ||
                 (rm_eff == RM_RUP && sel_sign);

        if (ovf) begin
            res_exp  = to_max ? EXP_MAXF : EXP_ALL1;
            res_mant = to_max ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end else begin
            res_exp  = sel_exp + {{(EXP_WIDTH-1){1'b0}}, cout};
            res_mant = cout ? {1'b1, {(WIDTH-1){1'b0}}} :
                              sel_mant + {{(WIDTH-1){1'b0}}, up};
        end
        res_flags = {nv, 1'b0, ovf, 1'b0, inexact | ovf};
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_mant_d  = out_mant_q;
        out_exp_d   = out_exp_q;
        out_sign_d  = out_sign_q;
        out_flags_d = out_flags_q;
        if (accept) begin
            ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            out_valid_d = 1'b1;
            out_id_d    = grant_idx;
            out_mant_d  = res_mant;
            out_exp_d   = res_exp;
            out_sign_d  = sel_sign;
            out_flags_d = res_flags;
        end else if (stage_free) begin
            out_valid_d = 1'b0;
        end
        acc_d = (bus.fflags_clr ? 5'b0 : acc_q) |
                ((out_valid_q && bus.out_ready) ? out_flags_q : 5'b0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_sign_q  <= 1'b0;
            out_flags_q <= '0;
            acc_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_mant_q  <= out_mant_d;
            out_exp_q   <= out_exp_d;
            out_sign_q  <= out_sign_d;
            out_flags_q <= out_flags_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_mant   = out_mant_q;
    assign bus.out_exp    = out_exp_q;
    assign bus.out_sign   = out_sign_q;
    assign bus.out_flags  = out_flags_q;
    assign bus.fflags_acc = acc_q;
endmodule
